// File: rtl/mesa_ascii2word_pkg.sv
// mesa_ascii2word_pkg: shared character constants, class encoding and hex decode helper
package mesa_ascii2word_pkg;

    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    typedef enum logic [1:0] {
        HEX     = 2'd0,
        DELIM   = 2'd1,
        ILLEGAL = 2'd2
    } char_class_t;

    typedef struct packed {
        char_class_t cls;
        logic [3:0]  nib;
    } hex_dec_t;

    // Letters A-F/a-f share the low nibble 1..6, so adding 9 gives 10..15.
    function automatic hex_dec_t hex_decode(input logic [7:0] c);
        hex_dec_t r;
        r.cls = ILLEGAL;
        r.nib = 4'h0;
        if (c inside {[8'h30:8'h39]}) begin
            r.cls = HEX;
            r.nib = c[3:0];
        end else if (c inside {[8'h41:8'h46], [8'h61:8'h66]}) begin
            r.cls = HEX;
            r.nib = c[3:0] + 4'd9;
        end else if (c inside {ASCII_SP, ASCII_LF, ASCII_CR, ASCII_COMMA}) begin
            r.cls = DELIM;
        end
        return r;
    endfunction

endpackage

// File: rtl/mesa_ascii2word_if.sv
// mesa_ascii2word_if: character input and word output handshake bundle
interface mesa_ascii2word_if #(
    parameter int NIBBLES = 8
);
    localparam int CNT_W = $clog2(NIBBLES + 1);

    logic                 rx_char_en;
    logic [7:0]           rx_char_d;
    logic                 rx_char_rdy;
    logic                 word_valid;
    logic                 word_rdy;
    logic [4*NIBBLES-1:0] word_d;
    logic [CNT_W-1:0]     word_nibs;
    logic                 err_pulse;

    modport master (
        output rx_char_en, rx_char_d, word_rdy,
        input  rx_char_rdy, word_valid, word_d, word_nibs, err_pulse
    );

    modport slave (
        input  rx_char_en, rx_char_d, word_rdy,
        output rx_char_rdy, word_valid, word_d, word_nibs, err_pulse
    );

endinterface

// File: rtl/mesa_ascii2word_hex_decode.sv
// mesa_hex_decode: combinational ASCII character classifier and hex nibble extractor
module mesa_hex_decode
    import mesa_ascii2word_pkg::*;
(
    input  logic [7:0] char_d,
    output hex_dec_t   dec
);

    assign dec = hex_decode(char_d);

endmodule

// File: rtl/mesa_ascii2word.sv
// mesa_ascii2word: assembles ASCII hex characters MSB-first into words with a valid/ready output
module mesa_ascii2word
    import mesa_ascii2word_pkg::*;
#(
    parameter int NIBBLES     = 8,
    parameter bit DELIM_FLUSH = 1'b1
) (
    input logic           clk,
    input logic           reset,
    mesa_ascii2word_if.slave bus
);

    localparam int CNT_W = $clog2(NIBBLES + 1);
    localparam int W     = 4 * NIBBLES;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NIBBLES);

    hex_dec_t         dec;
    logic [W-1:0]     acc;
    logic [W-1:0]     shifted;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             take;
    logic             is_hex;
    logic             full;
    logic             flush;
    logic             word_valid;
    logic [W-1:0]     word_d;
    logic [CNT_W-1:0] word_nibs;
    logic             err_pulse;

    mesa_hex_decode u_dec (
        .char_d (bus.rx_char_d),
        .dec    (dec)
    );

    assign bus.rx_char_rdy = !word_valid || bus.word_rdy;
    assign bus.word_valid  = word_valid;
    assign bus.word_d      = word_d;
    assign bus.word_nibs   = word_nibs;
    assign bus.err_pulse   = err_pulse;

    // Cast-truncation keeps the shift legal even when NIBBLES is 1.
    assign shifted = W'({acc, dec.nib});
    assign cnt_nx  = cnt + 1'b1;
    assign take    = bus.rx_char_en && bus.rx_char_rdy;
    assign is_hex  = take && dec.cls == HEX;
    assign full    = is_hex && cnt_nx == FULL;
    assign flush   = take && dec.cls == DELIM && cnt != '0 && DELIM_FLUSH;

    // Accumulator: shift in hex digits, clear on completion, delimiter or illegal character.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            acc <= (is_hex && !full) ? shifted : '0;
            cnt <= (is_hex && !full) ? cnt_nx : '0;
        end
    end

    // Output register: load on completion or flush, hold until consumed, pulse on illegal input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_valid <= 1'b0;
            word_d     <= '0;
            word_nibs  <= '0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= take && dec.cls == ILLEGAL;
            if (full || flush) begin
                word_valid <= 1'b1;
                word_d     <= full ? shifted : acc;
                word_nibs  <= full ? FULL : cnt;
            end else if (bus.word_rdy) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule
